pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, address width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, first fetch address after reset; bits [1:0] SHALL be 0.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries, power of two, >=2.
REQ-004 clk  in  1  all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 stall  in  1  pipeline hold request.
REQ-007 fetch_ready  in  1  instruction memory accepts the current fetch address.
REQ-008 redirect_valid / redirect_target  in  1 / XLEN  taken branch or jump and its target.
REQ-009 call  in  1  qualifies redirect_valid; pushes the return address.
REQ-010 ret_valid / ret_target  in  1 / XLEN  return; ret_target is the fallback when the RAS is empty.
REQ-011 trap_valid / trap_vector  in  1 / XLEN  trap entry and its handler address.
REQ-012 instr_addr  out  XLEN  current fetch address.
REQ-013 fetch_valid  out  1  instr_addr is a valid fetch request.
REQ-014 misaligned_fault  out  1  one-cycle pulse, rejected misaligned target.
REQ-015 ras_empty, ras_full  out  1 each  RAS occupancy flags.

Function
REQ-016 Handshake: a fetch completes on a rising edge with fetch_valid=1 and fetch_ready=1.
REQ-017 Handshake: while fetch_valid=1 and fetch_ready=0, instr_addr and fetch_valid SHALL hold, except on a flush (REQ-021).
REQ-018 FSM states: BOOT, RUN, FLUSH.
REQ-019 BOOT: entered on reset; fetch_valid=0 for exactly one cycle; then RUN with instr_addr=RESET_VECTOR, fetch_valid=1.
REQ-020 Event priority, evaluated each edge in RUN or FLUSH: trap_valid > redirect_valid > ret_valid > sequential.
REQ-021 Flush: a trap, redirect or ret arriving while a request is pending unaccepted SHALL withdraw that request: state FLUSH, fetch_valid=0 for one cycle, instr_addr=new target; then RUN with fetch_valid=!stall.
REQ-022 Trap: next instr_addr={trap_vector[XLEN-1:2],2'b00}; RAS cleared to empty in the same edge.
REQ-023 Redirect: next instr_addr=redirect_target.
REQ-024 Redirect with call: also push instr_addr+4 onto the RAS.
REQ-025 ret_valid with RAS non-empty: next instr_addr=top entry, pop.
REQ-026 ret_valid with RAS empty: next instr_addr=ret_target; no pop.
REQ-027 Misaligned target: redirect_target[1:0]!=0, or ret_target[1:0]!=0 when it is used, SHALL be ignored.
REQ-028 On a misaligned target: PC, RAS and handshake unchanged; misaligned_fault=1 on the following cycle only.
REQ-029 Sequential: on a completed fetch with no event, next instr_addr=instr_addr+4, modulo 2^XLEN (all-ones-minus-3 wraps to 0).
REQ-030 Stall, sampled when no request is pending unaccepted: next fetch_valid=0, instr_addr held; ignored while a request is pending.
REQ-031 Events during stall still update instr_addr and the RAS.
REQ-032 RAS full push: overwrite oldest entry (circular); count saturates at RAS_DEPTH; ras_full stays 1.
REQ-033 call and ret_valid in the same edge: redirect+call wins per priority; the ret is ignored.
REQ-034 ras_empty / ras_full SHALL be registered, consistent with the count after each edge.

Reset
REQ-035 reset SHALL asynchronously force: state=BOOT, instr_addr=RESET_VECTOR, fetch_valid=0, misaligned_fault=0, RAS count=0, ras_empty=1, ras_full=0.
REQ-036 Reset asserted mid-request SHALL abandon the request with no handshake completion; RAS contents are don't-care after reset.

Structure
REQ-037 Shared package SHALL hold the FSM state enum (BOOT/RUN/FLUSH) and the constant INSTR_BYTES=4.
REQ-038 Sub-module return_addr_stack (XLEN, RAS_DEPTH), with push, pop, clear, top, empty and full, SHALL hold the RAS.

Verification
REQ-039 Reset with RESET_VECTOR=0x100, fetch_ready=1 -> one BOOT cycle with fetch_valid=0, then instr_addr 0x100, 0x104, 0x108.
REQ-040 fetch_ready=0 for 3 cycles at 0x200 -> instr_addr and fetch_valid held; redirect to 0x400 in cycle 2 -> one fetch_valid=0 cycle, then 0x400.
REQ-041 RAS_DEPTH=4: 5 calls at 0x10..0x50 -> ras_full=1; 5 rets -> 0x54, 0x44, 0x34, 0x24, then ret_target.
REQ-042 redirect_target=0x302 -> PC unchanged, misaligned_fault high exactly one cycle.
REQ-043 trap_valid and redirect_valid together, trap_vector=0x803 -> instr_addr=0x800; ras_empty=1.
REQ-044 instr_addr=0xFFFFFFFC with a completed fetch -> 0x00000000; reset asserted mid-stall -> outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer slice.
// Holds the sequencer FSM state encoding and the instruction size.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } seq_state_e;

   localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_sequencer_ras.sv
// return_addr_stack: circular return-address stack with registered flags.
// Ports: clk, reset, push/push_addr, pop, clear, top, empty, full.
module return_addr_stack #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic [XLEN-1:0] push_addr,
   input  logic            pop,
   input  logic            clear,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            full
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

   logic [XLEN-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]   sp;
   logic [CW-1:0]   count;

   // sp points at the next free slot; when full, that slot holds the
   // oldest entry, so a push overwrites it and the stack stays circular.
   assign top = mem[sp - PW'(1)];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp    <= '0;
         count <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else if (clear) begin
         count <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else if (push) begin
         sp    <= sp + PW'(1);
         if (count != DEPTH_C)
            count <= count + CW'(1);
         empty <= 1'b0;
         full  <= (count >= DEPTH_C - CW'(1));
      end else if (pop && count != '0) begin
         sp    <= sp - PW'(1);
         count <= count - CW'(1);
         empty <= (count == CW'(1));
         full  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear)
         mem[sp] <= push_addr;
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address generator with handshake, flush and RAS.
// Ports: clk, reset, stall, fetch_ready, redirect/call, ret, trap in;
//        instr_addr, fetch_valid, misaligned_fault, ras_empty/full out.
module pc_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            fetch_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            call,
   input  logic            ret_valid,
   input  logic [XLEN-1:0] ret_target,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
   output logic [XLEN-1:0] instr_addr,
   output logic            fetch_valid,
   output logic            misaligned_fault,
   output logic            ras_empty,
   output logic            ras_full
);

   import pc_sequencer_pkg::*;

   localparam logic [XLEN-1:0] STEP  = XLEN'(INSTR_BYTES);
   localparam logic [XLEN-1:0] ALIGN = ~XLEN'(INSTR_BYTES - 1);

   seq_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_d;
   logic            fv_d;
   logic            fault_d;
   logic [XLEN-1:0] target;
   logic            hit;
   logic            pending;
   logic            done;
   logic            push;
   logic            pop;
   logic            clear;
   logic [XLEN-1:0] ras_top;

   assign pending = fetch_valid & ~fetch_ready;
   assign done    = fetch_valid & fetch_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= BOOT;
         instr_addr       <= RESET_VECTOR;
         fetch_valid      <= 1'b0;
         misaligned_fault <= 1'b0;
      end else begin
         state_q          <= state_d;
         instr_addr       <= pc_d;
         fetch_valid      <= fv_d;
         misaligned_fault <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = instr_addr;
      fv_d    = fetch_valid;
      fault_d = 1'b0;
      target  = '0;
      hit     = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      clear   = 1'b0;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
            pc_d    = RESET_VECTOR;
            fv_d    = 1'b1;
         end
         RUN, FLUSH: begin
            if (trap_valid) begin
               hit    = 1'b1;
               target = trap_vector & ALIGN;
               clear  = 1'b1;
            end else if (redirect_valid) begin
               if (redirect_target[1:0] != 2'b00) begin
                  fault_d = 1'b1;
               end else begin
                  hit    = 1'b1;
                  target = redirect_target;
                  push   = call;
               end
            end else if (ret_valid) begin
               if (!ras_empty) begin
                  hit    = 1'b1;
                  target = ras_top;
                  pop    = 1'b1;
               end else if (ret_target[1:0] != 2'b00) begin
                  fault_d = 1'b1;
               end else begin
                  hit    = 1'b1;
                  target = ret_target;
               end
            end
            // A rejected target freezes the whole sequencer for this edge.
            if (fault_d) begin
               state_d = state_q;
            end else if (hit) begin
               pc_d = target;
               if (pending) begin
                  state_d = FLUSH;
                  fv_d    = 1'b0;
               end else begin
                  state_d = RUN;
                  fv_d    = ~stall;
               end
            end else if (!pending) begin
               state_d = RUN;
               fv_d    = ~stall;
               if (done)
                  pc_d = instr_addr + STEP;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   return_addr_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_addr (instr_addr + STEP),
      .pop       (pop),
      .clear     (clear),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Linear stimulus, immediate assertions at each check point.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        fetch_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        call;
   logic        ret_valid;
   logic [31:0] ret_target;
   logic        trap_valid;
   logic [31:0] trap_vector;
   logic [31:0] instr_addr;
   logic        fetch_valid;
   logic        misaligned_fault;
   logic        ras_empty;
   logic        ras_full;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   pc_sequencer #(
      .XLEN         (32),
      .RESET_VECTOR (32'h100),
      .RAS_DEPTH    (4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .fetch_ready      (fetch_ready),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .call             (call),
      .ret_valid        (ret_valid),
      .ret_target       (ret_target),
      .trap_valid       (trap_valid),
      .trap_vector      (trap_vector),
      .instr_addr       (instr_addr),
      .fetch_valid      (fetch_valid),
      .misaligned_fault (misaligned_fault),
      .ras_empty        (ras_empty),
      .ras_full         (ras_full)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      redirect_valid = 1'b0;
      call           = 1'b0;
      ret_valid      = 1'b0;
      trap_valid     = 1'b0;
   endtask

   task automatic do_call(input logic [31:0] tgt);
      redirect_valid  = 1'b1;
      call            = 1'b1;
      redirect_target = tgt;
      tick();
   endtask

   initial begin
      reset           = 1'b1;
      stall           = 1'b0;
      fetch_ready     = 1'b1;
      redirect_target = '0;
      ret_target      = '0;
      trap_vector     = '0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_addr", instr_addr, 32'h100);
      check("rst_fv", {31'd0, fetch_valid}, 32'd0);
      check("rst_fault", {31'd0, misaligned_fault}, 32'd0);
      check("rst_empty", {31'd0, ras_empty}, 32'd1);
      check("rst_full", {31'd0, ras_full}, 32'd0);

      reset = 1'b0;
      #1;
      check("boot_fv", {31'd0, fetch_valid}, 32'd0);
      tick();
      check("run_fv", {31'd0, fetch_valid}, 32'd1);
      check("seq0", instr_addr, 32'h100);
      tick();
      check("seq1", instr_addr, 32'h104);
      tick();
      check("seq2", instr_addr, 32'h108);

      redirect_valid  = 1'b1;
      redirect_target = 32'h200;
      tick();
      idle();
      check("redir200", instr_addr, 32'h200);
      fetch_ready = 1'b0;
      tick();
      check("hold1_addr", instr_addr, 32'h200);
      check("hold1_fv", {31'd0, fetch_valid}, 32'd1);
      stall = 1'b1;
      tick();
      check("hold2_addr", instr_addr, 32'h200);
      check("hold2_fv", {31'd0, fetch_valid}, 32'd1);
      stall           = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h400;
      tick();
      idle();
      check("flush_fv", {31'd0, fetch_valid}, 32'd0);
      check("flush_addr", instr_addr, 32'h400);
      fetch_ready = 1'b1;
      tick();
      check("post_fl_fv", {31'd0, fetch_valid}, 32'd1);
      check("post_fl_addr", instr_addr, 32'h400);
      tick();
      check("seq404", instr_addr, 32'h404);

      stall = 1'b1;
      tick();
      check("stall_fv", {31'd0, fetch_valid}, 32'd0);
      check("stall_addr", instr_addr, 32'h408);
      tick();
      check("stall_hold", instr_addr, 32'h408);
      redirect_valid  = 1'b1;
      redirect_target = 32'h10;
      tick();
      idle();
      check("stall_redir", instr_addr, 32'h10);
      check("stall_redir_fv", {31'd0, fetch_valid}, 32'd0);
      stall = 1'b0;

      do_call(32'h20);
      check("call1_empty", {31'd0, ras_empty}, 32'd0);
      do_call(32'h30);
      do_call(32'h40);
      do_call(32'h50);
      check("call4_full", {31'd0, ras_full}, 32'd1);
      do_call(32'h60);
      check("call5_full", {31'd0, ras_full}, 32'd1);
      check("call5_addr", instr_addr, 32'h60);
      idle();
      ret_valid  = 1'b1;
      ret_target = 32'h700;
      tick();
      check("ret1", instr_addr, 32'h54);
      check("ret1_full", {31'd0, ras_full}, 32'd0);
      tick();
      check("ret2", instr_addr, 32'h44);
      tick();
      check("ret3", instr_addr, 32'h34);
      tick();
      check("ret4", instr_addr, 32'h24);
      check("ret4_empty", {31'd0, ras_empty}, 32'd1);
      tick();
      check("ret5_fallback", instr_addr, 32'h700);

      redirect_valid  = 1'b1;
      call            = 1'b1;
      redirect_target = 32'h900;
      tick();
      check("call_ret_addr", instr_addr, 32'h900);
      check("call_ret_empty", {31'd0, ras_empty}, 32'd0);
      idle();
      ret_valid = 1'b1;
      tick();
      idle();
      check("ret_pop", instr_addr, 32'h704);

      redirect_valid  = 1'b1;
      redirect_target = 32'h302;
      tick();
      idle();
      check("mis_addr", instr_addr, 32'h704);
      check("mis_fault", {31'd0, misaligned_fault}, 32'd1);
      tick();
      check("mis_clear", {31'd0, misaligned_fault}, 32'd0);
      check("mis_next", instr_addr, 32'h708);

      ret_valid  = 1'b1;
      ret_target = 32'h502;
      tick();
      idle();
      check("misret_addr", instr_addr, 32'h708);
      check("misret_fault", {31'd0, misaligned_fault}, 32'd1);
      tick();
      check("misret_next", instr_addr, 32'h70C);

      do_call(32'hA00);
      idle();
      check("pre_trap_empty", {31'd0, ras_empty}, 32'd0);
      trap_valid      = 1'b1;
      trap_vector     = 32'h803;
      redirect_valid  = 1'b1;
      redirect_target = 32'h404;
      tick();
      idle();
      check("trap_addr", instr_addr, 32'h800);
      check("trap_empty", {31'd0, ras_empty}, 32'd1);

      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      tick();
      idle();
      check("top_addr", instr_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap", instr_addr, 32'h0);

      stall = 1'b1;
      tick();
      check("pre_rst_fv", {31'd0, fetch_valid}, 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check("async_addr", instr_addr, 32'h100);
      check("async_fv", {31'd0, fetch_valid}, 32'd0);
      check("async_empty", {31'd0, ras_empty}, 32'd1);
      check("async_full", {31'd0, ras_full}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
